// File: rtl/pcie_ats_pkg.sv
// Shared ATS definitions: RQ descriptor field offsets, message constants,
// the invalidation-completion request record and a descriptor builder.
package pcie_ats_pkg;

  localparam int DESC_WIDTH    = 128;
  localparam int DESC_BYTES    = DESC_WIDTH / 8;

  localparam int ITAG_VEC_LSB  = 0;
  localparam int CC_LSB        = 32;
  localparam int REQ_ID_LSB    = 48;
  localparam int DWORD_CNT_LSB = 64;
  localparam int REQ_TYPE_LSB  = 75;
  localparam int POISON_BIT    = 79;
  localparam int TAG_LSB       = 96;
  localparam int MSG_CODE_LSB  = 104;
  localparam int ROUTING_LSB   = 112;

  localparam logic [3:0] REQ_TYPE_ATS_MSG = 4'b1110;
  localparam logic [2:0] ROUTE_BY_ID      = 3'b010;
  localparam logic [7:0] MSG_CODE_INV_REQ = 8'h01;
  localparam logic [7:0] MSG_CODE_INV_CPL = 8'h02;

  typedef struct packed {
    logic [4:0]  itag;
    logic [15:0] id;
    logic [2:0]  cc;
  } ats_req_t;

  localparam int ATS_REQ_WIDTH = $bits(ats_req_t);

  function automatic logic [DESC_WIDTH-1:0] build_inv_cpl_desc(input ats_req_t req,
                                                               input logic [7:0] code);
    logic [DESC_WIDTH-1:0] d;
    d = '0;
    d[ITAG_VEC_LSB +: 32]  = 32'd1 << req.itag;
    d[CC_LSB +: 3]         = req.cc;
    d[REQ_ID_LSB +: 16]    = req.id;
    d[DWORD_CNT_LSB +: 11] = 11'd0;
    d[REQ_TYPE_LSB +: 4]   = REQ_TYPE_ATS_MSG;
    d[POISON_BIT]          = 1'b0;
    d[TAG_LSB +: 8]        = {3'b000, req.itag};
    d[MSG_CODE_LSB +: 8]   = code;
    d[ROUTING_LSB +: 3]    = ROUTE_BY_ID;
    return d;
  endfunction

endpackage

// File: rtl/ats_req_fifo.sv
// Synchronous FIFO for pending invalidation completions; head word is
// readable combinationally so the output stage can load it the same cycle.
module ats_req_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop && !empty)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pcie_rq_ats_inv_cpl_tx.sv
// Buffers invalidation-completion requests and emits one single-beat ATS
// Invalidation Completion message per request on the RQ AXI-stream.
module pcie_rq_ats_inv_cpl_tx
  import pcie_ats_pkg::*;
#(
  parameter int         AXIS_DATA_WIDTH = 512,
  parameter int         FIFO_DEPTH      = 8,
  parameter logic [7:0] INV_CPL_CODE    = MSG_CODE_INV_CPL
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [4:0]                   req_itag,
  input  logic [15:0]                  req_id,
  input  logic [2:0]                   req_cc,
  output logic [AXIS_DATA_WIDTH-1:0]   rq_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] rq_axis_tkeep,
  output logic                         rq_axis_tvalid,
  output logic                         rq_axis_tlast,
  input  logic                         rq_axis_tready,
  output logic [15:0]                  cpl_sent_count,
  output logic                         busy
);

  localparam int KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  ats_req_t                   push_req;
  ats_req_t                   head_req;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       load;
  logic [AXIS_DATA_WIDTH-1:0] tdata_next;
  logic [KEEP_WIDTH-1:0]      keep_desc;

  logic                       tvalid_reg;
  logic [AXIS_DATA_WIDTH-1:0] tdata_reg;
  logic [KEEP_WIDTH-1:0]      tkeep_reg;
  logic [15:0]                count_reg;

  assign push_req = '{itag: req_itag, id: req_id, cc: req_cc};

  ats_req_fifo #(
    .WIDTH (ATS_REQ_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (req_valid),
    .wr_data (push_req),
    .pop     (load),
    .rd_data (head_req),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign req_ready = !fifo_full;

  // Only the descriptor bytes are enabled; the rest of the beat is padding.
  for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_keep
    assign keep_desc[gi] = (gi < DESC_BYTES);
  end

  // Refill the output stage whenever it is empty or its beat is leaving now.
  assign load = !fifo_empty && (!tvalid_reg || rq_axis_tready);

  always_comb begin
    tdata_next = '0;
    tdata_next[DESC_WIDTH-1:0] = build_inv_cpl_desc(head_req, INV_CPL_CODE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tkeep_reg  <= '0;
      count_reg  <= 16'd0;
    end else begin
      if (load) begin
        tvalid_reg <= 1'b1;
        tdata_reg  <= tdata_next;
        tkeep_reg  <= keep_desc;
      end else if (rq_axis_tready) begin
        tvalid_reg <= 1'b0;
      end
      if (tvalid_reg && rq_axis_tready)
        count_reg <= count_reg + 16'd1;
    end
  end

  assign rq_axis_tdata  = tdata_reg;
  assign rq_axis_tkeep  = tkeep_reg;
  assign rq_axis_tvalid = tvalid_reg;
  assign rq_axis_tlast  = tvalid_reg;
  assign cpl_sent_count = count_reg;
  assign busy           = !fifo_empty || tvalid_reg;

endmodule

// File: tb/tb_pcie_rq_ats_inv_cpl_tx.sv
// Directed bench for the ATS invalidation-completion RQ transmitter.
module tb_pcie_rq_ats_inv_cpl_tx;

  localparam int W  = 512;
  localparam int KW = W / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_itag;
  logic [15:0]   req_id;
  logic [2:0]    req_cc;
  logic [W-1:0]  rq_axis_tdata;
  logic [KW-1:0] rq_axis_tkeep;
  logic          rq_axis_tvalid;
  logic          rq_axis_tlast;
  logic          rq_axis_tready;
  logic [15:0]   cpl_sent_count;
  logic          busy;

  int errors = 0;
  int checks = 0;

  pcie_rq_ats_inv_cpl_tx #(
    .AXIS_DATA_WIDTH (W),
    .FIFO_DEPTH      (8),
    .INV_CPL_CODE    (8'h02)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_itag       (req_itag),
    .req_id         (req_id),
    .req_cc         (req_cc),
    .rq_axis_tdata  (rq_axis_tdata),
    .rq_axis_tkeep  (rq_axis_tkeep),
    .rq_axis_tvalid (rq_axis_tvalid),
    .rq_axis_tlast  (rq_axis_tlast),
    .rq_axis_tready (rq_axis_tready),
    .cpl_sent_count (cpl_sent_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_desc(input logic [4:0] itag, input logic [15:0] id,
                                            input logic [2:0] cc);
    logic [127:0] d;
    d = '0;
    d[31:0]    = 32'd1 << itag;
    d[34:32]   = cc;
    d[63:48]   = id;
    d[78:75]   = 4'b1110;
    d[103:96]  = {3'b000, itag};
    d[111:104] = 8'h02;
    d[114:112] = 3'b010;
    return d;
  endfunction

  initial begin
    logic [127:0] held;
    int acc;
    int beats;
    int sent;
    int pushed;
    int cyc;
    logic v_now;
    logic r_now;
    logic drive;

    rst = 1'b1; req_valid = 1'b0; req_itag = '0; req_id = '0; req_cc = '0;
    rq_axis_tready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    $display("reset: tvalid=%0b ready=%0b count=%0d", rq_axis_tvalid, req_ready, cpl_sent_count);
    check("rst_tvalid", rq_axis_tvalid, 1'b0);
    check("rst_tlast",  rq_axis_tlast,  1'b0);
    check("rst_tdata",  rq_axis_tdata[127:0], 128'd0);
    check("rst_tkeep",  rq_axis_tkeep, 64'd0);
    check("rst_count",  cpl_sent_count, 16'd0);
    check("rst_busy",   busy, 1'b0);
    check("rst_ready",  req_ready, 1'b1);

    // Single request, tready high.
    rq_axis_tready = 1'b1;
    req_valid = 1'b1; req_itag = 5'd5; req_id = 16'h0100; req_cc = 3'd1;
    tick();
    req_valid = 1'b0;
    check("single_lat_tvalid0", rq_axis_tvalid, 1'b0);
    tick();
    $display("single: tvalid=%0b tdata=%h", rq_axis_tvalid, rq_axis_tdata[127:0]);
    check("single_tvalid",  rq_axis_tvalid, 1'b1);
    check("single_itagvec", rq_axis_tdata[31:0], 32'h20);
    check("single_cc",      rq_axis_tdata[34:32], 3'd1);
    check("single_id",      rq_axis_tdata[63:48], 16'h0100);
    check("single_tag",     rq_axis_tdata[103:96], 8'h05);
    check("single_code",    rq_axis_tdata[111:104], 8'h02);
    check("single_type",    rq_axis_tdata[78:75], 4'b1110);
    check("single_desc",    rq_axis_tdata[127:0], exp_desc(5'd5, 16'h0100, 3'd1));
    check("single_upper",   |rq_axis_tdata[W-1:128], 1'b0);
    check("single_tkeep",   rq_axis_tkeep, 64'h0000_0000_0000_FFFF);
    check("single_tlast",   rq_axis_tlast, 1'b1);
    tick();
    check("single_count",   cpl_sent_count, 16'd1);
    check("single_idle",    rq_axis_tvalid, 1'b0);
    check("single_busy",    busy, 1'b0);

    // Backpressure hold for 10 cycles.
    rq_axis_tready = 1'b0;
    req_valid = 1'b1; req_itag = 5'd7; req_id = 16'hABCD; req_cc = 3'd3;
    tick();
    req_valid = 1'b0;
    tick();
    held = exp_desc(5'd7, 16'hABCD, 3'd3);
    for (int i = 0; i < 10; i++) begin
      check("stall_tvalid", rq_axis_tvalid, 1'b1);
      check("stall_tdata",  rq_axis_tdata[127:0], held);
      check("stall_count",  cpl_sent_count, 16'd1);
      tick();
    end
    rq_axis_tready = 1'b1;
    tick();
    $display("stall release: count=%0d tvalid=%0b", cpl_sent_count, rq_axis_tvalid);
    check("stall_count_after", cpl_sent_count, 16'd2);
    check("stall_idle",        rq_axis_tvalid, 1'b0);

    // Fill: 8 in FIFO + 1 in output register.
    rq_axis_tready = 1'b0;
    acc = 0;
    for (int c = 0; c < 14; c++) begin
      drive = (acc < 10);
      req_valid = drive;
      req_itag = acc[4:0]; req_id = 16'h1000 + acc[15:0]; req_cc = acc[2:0];
      r_now = req_ready;
      tick();
      if (drive && r_now) acc++;
    end
    req_valid = 1'b0;
    $display("fill: accepted=%0d ready=%0b", acc, req_ready);
    check("fill_accepted", acc, 9);
    check("fill_ready_low", req_ready, 1'b0);
    check("fill_busy", busy, 1'b1);
    rq_axis_tready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 1) check("fill_ready_rise", req_ready, 1'b1);
      check("drain_tvalid", rq_axis_tvalid, 1'b1);
      check("drain_desc", rq_axis_tdata[127:0],
            exp_desc(k[4:0], 16'h1000 + k[15:0], k[2:0]));
      $display("drain beat %0d: itag=%0d", k, rq_axis_tdata[103:96]);
      tick();
    end
    check("drain_idle", rq_axis_tvalid, 1'b0);
    check("drain_count", cpl_sent_count, 16'd11);

    // Back-to-back 32 requests at full rate.
    beats = 0;
    for (int c = 0; c < 36; c++) begin
      req_valid = (c < 32);
      req_itag = c[4:0]; req_id = 16'h2000 + c[15:0]; req_cc = c[2:0];
      check("b2b_tvalid", rq_axis_tvalid, (c >= 2 && c <= 33));
      if (rq_axis_tvalid) begin
        check("b2b_desc", rq_axis_tdata[127:0],
              exp_desc(beats[4:0], 16'h2000 + beats[15:0], beats[2:0]));
        beats++;
      end
      if (c < 32) check("b2b_ready", req_ready, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    $display("b2b: beats=%0d count=%0d", beats, cpl_sent_count);
    check("b2b_beats", beats, 32);
    check("b2b_count", cpl_sent_count, 16'd43);

    // Reset while stalled with completions queued.
    rq_axis_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_itag = 5'd20 + c[4:0]; req_id = 16'h3000; req_cc = 3'd0;
      tick();
    end
    req_valid = 1'b0;
    tick();
    check("pre_rst_tvalid", rq_axis_tvalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("mid reset: tvalid=%0b busy=%0b count=%0d", rq_axis_tvalid, busy, cpl_sent_count);
    check("mrst_tvalid", rq_axis_tvalid, 1'b0);
    check("mrst_busy",   busy, 1'b0);
    check("mrst_count",  cpl_sent_count, 16'd0);
    check("mrst_ready",  req_ready, 1'b1);
    rq_axis_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mrst_no_stale", rq_axis_tvalid, 1'b0);
    end

    // Counter wrap: 65535 transfers, then one more.
    sent = 0; pushed = 0; cyc = 0;
    while (sent < 65535 && cyc < 70000) begin
      drive = (pushed < 65536);
      req_valid = drive; req_itag = pushed[4:0]; req_id = pushed[15:0]; req_cc = 3'd0;
      v_now = rq_axis_tvalid; r_now = req_ready;
      tick();
      if (v_now) sent++;
      if (drive && r_now) pushed++;
      cyc++;
    end
    check("wrap_reach", sent, 65535);
    check("wrap_ffff", cpl_sent_count, 16'hFFFF);
    cyc = 0;
    while (sent < 65536 && cyc < 100) begin
      drive = (pushed < 65536);
      req_valid = drive;
      v_now = rq_axis_tvalid; r_now = req_ready;
      tick();
      if (v_now) sent++;
      if (drive && r_now) pushed++;
      cyc++;
    end
    req_valid = 1'b0;
    $display("wrap: sent=%0d count=%0d", sent, cpl_sent_count);
    check("wrap_reach2", sent, 65536);
    check("wrap_zero", cpl_sent_count, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_rq_ats_inv_cpl_tx.md
# pcie_rq_ats_inv_cpl_tx

Transmit side of ATS invalidation handling: accepts invalidation-completion requests (ITag, requester ID, completion count) from the CQ-side invalidation snooper, buffers them, and emits one single-beat ATS Invalidation Completion message TLP per request on the PCIe RQ AXI-stream. It sits between the CQ snoop logic and the RQ arbiter and fully honours RQ backpressure, so no completion is dropped while the RQ interface is stalled.

## Interface
- AXIS_DATA_WIDTH, 512, RQ tdata width (≥128)
- FIFO_DEPTH, 8, request buffer depth; power of 2, ≥2
- INV_CPL_CODE, 8'h02, message code placed in Invalidation Completion
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- req_valid  in  1  completion request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_itag  in  5  ITag of the invalidate request being completed
- req_id  in  16  requester ID of invalidate request (destination of completion)
- req_cc  in  3  completion count (CC)
- rq_axis_tdata  out  AXIS_DATA_WIDTH  RQ descriptor beat
- rq_axis_tkeep  out  AXIS_DATA_WIDTH/8  byte enables
- rq_axis_tvalid  out  1  beat valid
- rq_axis_tlast  out  1  always 1 when tvalid (single-beat TLP)
- rq_axis_tready  in  1  RQ ready
- cpl_sent_count  out  16  wrapping count of completions transferred on RQ
- busy  out  1  FIFO non-empty or output beat pending

## Operation
- req_ready = !fifo_full; no push when full even if a pop occurs same cycle.
- Accepted request written to FIFO {itag, id, cc}.
- Output register: loaded from FIFO head when output empty or current beat completes (tvalid && tready) and FIFO non-empty; otherwise holds.
- Descriptor (all other bits 0): [31:0] ITag vector = 1 << itag; [34:32] cc; [63:48] req_id; [74:64] DW count = 0; [78:75] req_type = 4'b1110 (ATS message); [79] poison = 0; [103:96] tag = {3'b0, itag}; [111:104] INV_CPL_CODE; [114:112] routing = 3'b010 (route by ID); [127] = 0.
- tkeep: lower 16 bytes (descriptor) set, remainder 0.
- While tvalid && !tready: tdata/tkeep/tlast stable, tvalid stays 1 (AXIS rule).
- cpl_sent_count increments on each tvalid && tready; wraps 0xFFFF→0.
- Order preserved: completions leave in acceptance order.

## Timing
- Reset values: rq_axis_tvalid 0, tlast 0, tdata 0, tkeep 0, cpl_sent_count 0, busy 0, req_ready 1 (in first cycle after reset deassert), FIFO empty.
- Latency: request accepted at edge N → tvalid high after edge N+1 (2 cycles), if output register idle.
- Throughput: one completion per cycle with tready held high.
- Full: FIFO_DEPTH entries + 1 in output register can be outstanding; req_ready drops after the edge on which the FIFO becomes full, rises the cycle after a pop.
- Simultaneous push and pop with FIFO empty and output empty: no bypass; push goes to FIFO, beat appears next cycle.
- Reset mid-operation (including tvalid && !tready): all queued and pending completions discarded, tvalid 0 on the next cycle, counter cleared.
- tready while tvalid 0: ignored.

## Structure
- Shared package pcie_ats_pkg: descriptor field offsets, REQ_TYPE_ATS_MSG 4'b1110, ROUTE_BY_ID 3'b010, message-code constants (invalidate request / completion), request struct {itag, id, cc}.
- Sub-module ats_req_fifo: synchronous FIFO, width 24, depth FIFO_DEPTH, full/empty flags, pointer-plus-wrap-bit scheme.

## Test plan
- Single request itag=5, id=16'h0100, cc=1, tready=1 → one beat 2 cycles later: [31:0]=32'h20, [34:32]=1, [63:48]=16'h0100, [103:96]=8'h05, [111:104]=8'h02, [78:75]=4'b1110, tlast=1; cpl_sent_count=1.
- tready low for 10 cycles with beat pending → tdata/tvalid stable throughout; transferred on first tready=1; count increments once.
- tready held 0, push 10 requests → req_ready drops after 9 accepted (8 FIFO + 1 output); release tready → 9 beats in order, itags match acceptance order.
- Back-to-back 32 requests, tready=1 → 32 consecutive beats with tvalid high every cycle after the first; count=32.
- Assert rst while 4 completions queued and tvalid && !tready → next cycle tvalid=0, busy=0, count=0, req_ready=1; no stale beat after reset.
- Preload count near wrap (65535 transfers) → one more transfer yields cpl_sent_count=0.
